ring_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource among N requesters using a one-hot rotating priority ring. Priority rotates like the team's ring counter, so the last-served requester always becomes lowest priority. An optional per-grant cycle limit stops any single requester from monopolising the resource. Sits between requester blocks and the shared datapath; its grant vector drives the resource's input mux and enable.

---
 rtl/ring_arb_pkg.sv | 33 +++
 rtl/ring_rr_pick.sv | 45 ++++
 rtl/ring_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_ring_rr_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring round-robin arbiter: state encoding,
// a constant-foldable clog2 and a one-hot rotate-left used to advance the priority ring.
package ring_arb_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Rotate the low n bits of v left by one; bits at and above n come back as zero.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        r[(i + 1) % n] = v[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_rr_pick.sv
// Combinational rotating-priority picker: the first set req bit at or above the
// one-hot ptr position (wrapping around) wins.
module ring_rr_pick
  import ring_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win,
  output logic         any
);

  int unsigned start_idx;

  always_comb begin
    start_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) begin
        start_idx = i;
      end
    end
  end

  always_comb begin
    int unsigned idx;
    logic        found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = start_idx + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and an optional
// per-grant cycle limit; registered one-hot grant with zero-gap handover.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int HOLD_W = 4,
  localparam int ID_W   = clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req,
  input  logic [HOLD_W-1:0] max_hold,
  output logic [N-1:0]      grant,
  output logic              grant_valid,
  output logic [ID_W-1:0]   grant_id,
  output logic [N-1:0]      ptr
);

  state_e            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              gv_q, gv_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N-1:0]      ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0] lim_q, lim_d;

  logic [N-1:0]      rot_ptr;
  logic [N-1:0]      pick_ptr;
  logic [N-1:0]      win;
  logic              win_any;
  logic [ID_W-1:0]   win_id;
  logic              held_req;
  logic              forced;
  logic              release_now;

  assign rot_ptr  = N'(rotl1(MAX_N'(grant_q), N));
  assign held_req = |(req & grant_q);
  assign forced   = (lim_q != '0) && (cnt_q == lim_q - 1'b1);
  assign release_now = (state_q == GRANT) && (!held_req || forced);

  // On release the search restarts just past the outgoing requester.
  assign pick_ptr = release_now ? rot_ptr : ptr_q;

  ring_rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .win (win),
    .any (win_any)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gv_d    = gv_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    unique case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = GRANT;
          grant_d = win;
          gv_d    = 1'b1;
          id_d    = win_id;
          cnt_d   = '0;
          lim_d   = max_hold;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = rot_ptr;
          if (win_any) begin
            grant_d = win;
            gv_d    = 1'b1;
            id_d    = win_id;
            cnt_d   = '0;
            lim_d   = max_hold;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            gv_d    = 1'b0;
            id_d    = '0;
            cnt_d   = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gv_q    <= 1'b0;
      id_q    <= '0;
      ptr_q   <= N'(1);
      cnt_q   <= '0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gv_q    <= gv_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = gv_q;
  assign grant_id    = id_q;
  assign ptr         = ptr_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, HOLD_W=4) with hand-computed expectations.
module tb_ring_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] max_hold;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] ptr;

  int pass_cnt;
  int fail_cnt;
  int total;

  ring_rr_arbiter #(.N(4), .HOLD_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .max_hold    (max_hold),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .ptr         (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic gv,
                         input logic [1:0] id, input logic [3:0] p);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(gv));
    chk({tag, ".id"}, 32'(grant_id), 32'(id));
    chk({tag, ".ptr"}, 32'(ptr), 32'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_g;
    pass_cnt = 0;
    fail_cnt = 0;
    total    = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    max_hold = 4'd0;
    step();
    step();
    chk_out("reset", 4'b0000, 1'b0, 2'd0, 4'b0001);
    rst_n = 1'b1;

    // Forced release: each requester holds exactly 3 cycles, then wraps to 0001.
    max_hold = 4'd3;
    req      = 4'b1111;
    for (int i = 0; i < 13; i++) begin
      step();
      exp_g = 4'b0001 << ((i / 3) % 4);
      chk($sformatf("forced[%0d].grant", i), 32'(grant), 32'(exp_g));
      chk($sformatf("forced[%0d].valid", i), 32'(grant_valid), 32'd1);
      chk($sformatf("forced[%0d].id", i), 32'(grant_id), 32'((i / 3) % 4));
    end
    chk("forced.ptr_end", 32'(ptr), 32'b0001);
    req = 4'b0000;
    step();
    chk_out("forced_idle", 4'b0000, 1'b0, 2'd0, 4'b0010);

    // Asynchronous reset mid-cycle while a grant is active.
    max_hold = 4'd0;
    req      = 4'b1111;
    step();
    chk_out("pre_reset", 4'b0010, 1'b1, 2'd1, 4'b0010);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 4'b0000, 1'b0, 2'd0, 4'b0001);
    step();
    chk_out("reset_held", 4'b0000, 1'b0, 2'd0, 4'b0001);
    req   = 4'b0000;
    rst_n = 1'b1;
    step();
    chk_out("post_reset", 4'b0000, 1'b0, 2'd0, 4'b0001);

    // Voluntary release with zero-gap handover.
    req = 4'b0110;
    step();
    chk_out("vol_first", 4'b0010, 1'b1, 2'd1, 4'b0001);
    step();
    chk_out("vol_hold", 4'b0010, 1'b1, 2'd1, 4'b0001);
    req = 4'b0100;
    step();
    chk_out("vol_handover", 4'b0100, 1'b1, 2'd2, 4'b0100);
    req = 4'b0000;
    step();
    chk_out("vol_idle", 4'b0000, 1'b0, 2'd0, 4'b1000);

    // Wrap-around fairness from ptr=1000.
    req = 4'b1001;
    step();
    chk_out("wrap_first", 4'b1000, 1'b1, 2'd3, 4'b1000);
    req = 4'b0001;
    step();
    chk_out("wrap_second", 4'b0001, 1'b1, 2'd0, 4'b0001);
    req = 4'b0000;
    step();
    chk_out("wrap_idle", 4'b0000, 1'b0, 2'd0, 4'b0010);

    // Other requesters toggling while 0010 holds the grant.
    req = 4'b0010;
    step();
    chk_out("noise_grant", 4'b0010, 1'b1, 2'd1, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      req = (i % 2 == 0) ? 4'b1011 : 4'b0010;
      step();
      chk_out($sformatf("noise[%0d]", i), 4'b0010, 1'b1, 2'd1, 4'b0010);
    end
    req = 4'b0000;
    step();
    chk_out("noise_release", 4'b0000, 1'b0, 2'd0, 4'b0100);

    // Lone requester with limit 2 is re-granted back-to-back.
    max_hold = 4'd2;
    req      = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_out($sformatf("single[%0d]", i), 4'b0100, 1'b1, 2'd2,
              (i < 2) ? 4'b0100 : 4'b1000);
    end
    req = 4'b0000;
    step();
    chk_out("single_idle", 4'b0000, 1'b0, 2'd0, 4'b1000);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
